// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the tagged processor bus.
// Accepts BUS_LOAD / BUS_STORE requests, returns a request tag in the same
// cycle and delivers load data with that tag LATENCY cycles later.
//
// Optional feature macro: MEM_RESP_BOUNDS_CHECK_EN
//   defined   : requests whose word index is >= DEPTH are rejected
//   undefined : word index wraps modulo DEPTH, every aligned request accepted
//
// Parameters
//   LATENCY           load acceptance to data return, in cycles (1..14)
//   DEPTH             backing array size in 32-bit words (power of two)
// Ports
//   clk               system clock, rising edge
//   rst               synchronous active-low reset
//   proc2mem_command  BUS_NONE / BUS_LOAD / BUS_STORE (other codes ignored)
//   proc2mem_addr     byte address, word index = addr[31:2]
//   proc2mem_data     store data
//   mem2proc_response tag of the request accepted this cycle (combinational), 0 = none
//   mem2proc_data     returning load data (0 when no return)
//   mem2proc_tag      tag of the returning load, 0 = none (registered)
module mem_responder #(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned DEPTH   = 16384
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  proc2mem_command,
    input  logic [31:0] proc2mem_addr,
    input  logic [31:0] proc2mem_data,
    output logic [3:0]  mem2proc_response,
    output logic [31:0] mem2proc_data,
    output logic [3:0]  mem2proc_tag
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [1:0]  BUS_LOAD  = 2'h1;
    localparam logic [1:0]  BUS_STORE = 2'h2;

    // One return-pipeline stage; tag/data are zero whenever valid is low.
    typedef struct packed {
        logic        valid;
        logic [3:0]  tag;
        logic [31:0] data;
    } ret_t;

    logic [31:0]   r_mem [DEPTH];
    ret_t          r_pipe [LATENCY];
    logic [3:0]    r_next_tag;

    logic          w_is_load;
    logic          w_is_store;
    logic          w_in_range;
    logic          w_accept;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_rd_data;
    ret_t          w_stage_in;
    logic          w_unused;

    // Request decode, acceptance and array index.
    always_comb begin
        w_is_load  = (proc2mem_command == BUS_LOAD);
        w_is_store = (proc2mem_command == BUS_STORE);
`ifdef MEM_RESP_BOUNDS_CHECK_EN
        w_in_range = (proc2mem_addr[31:2] < 30'(DEPTH));
        // Out-of-range addresses never reach the array index.
        w_idx      = w_in_range ? proc2mem_addr[AW+1:2] : '0;
`else
        w_in_range = 1'b1;
        w_idx      = proc2mem_addr[AW+1:2];
`endif
        w_accept   = rst && (w_is_load || w_is_store) &&
                     (proc2mem_addr[1:0] == 2'b00) && w_in_range;
    end

    // Read happens in the request cycle, ahead of any write on the same edge.
    assign w_rd_data = r_mem[w_idx];

    always_comb begin
        w_stage_in = '0;
        if (w_accept && w_is_load) begin
            w_stage_in.valid = 1'b1;
            w_stage_in.tag   = r_next_tag;
            w_stage_in.data  = w_rd_data;
        end
    end

    assign mem2proc_response = w_accept ? r_next_tag : 4'd0;

    // Return pipeline and tag counter; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                r_pipe[i] <= '0;
            end
            r_next_tag <= 4'd1;
        end else begin
            r_pipe[0] <= w_stage_in;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
            if (w_accept) begin
                // Tag 0 means "nothing", so the counter wraps 15 -> 1.
                r_next_tag <= (r_next_tag == 4'd15) ? 4'd1 : r_next_tag + 4'd1;
            end
        end
    end

    // Backing array write port.
    always_ff @(posedge clk) begin
        if (w_accept && w_is_store) begin
            r_mem[w_idx] <= proc2mem_data;
        end
    end

    assign mem2proc_tag  = r_pipe[LATENCY-1].tag;
    assign mem2proc_data = r_pipe[LATENCY-1].data;

    // Address bits above the index and the last valid bit carry no function here.
    assign w_unused = ^{proc2mem_addr[31:AW+2], r_pipe[LATENCY-1].valid};

endmodule
